bf_exec_sequencer: RTL and testbench
====================================

// Module: bf_exec_sequencer
// PURPOSE
//  Fetch/decode/execute controller for the Brainf*ck core inside tt_um_brainfck_asic.
//  Walks program memory, drives the tape-memory port, handles loop bracket matching and
//  the byte in/out handshakes. Sits between program ROM, tape RAM and the pin I/O mux.
// PARAMETERS
//  PC_W     8  program address width (program length 2^PC_W bytes)
//  DP_W     8  tape data-pointer width (tape 2^DP_W cells, 8-bit each)
//  DEPTH_W  4  loop nesting counter width (max depth 2^DEPTH_W-1)
// PORTS
//  clk         in   1     clock; all state updates on rising edge
//  rst         in   1     synchronous reset, active-high
//  start       in   1     begin run from pc=0, dp=0 (sampled in IDLE/HALT/ERR)
//  prog_addr   out  PC_W  program address (= pc)
//  prog_data   in   8     opcode at prog_addr, combinational (same-cycle) read
//  tape_addr   out  DP_W  tape address (= dp)
//  tape_rdata  in   8     cell at tape_addr, combinational read
//  tape_wdata  out  8     write data
//  tape_we     out  1     write strobe; RAM writes on the edge where tape_we=1
//  out_data    out  8     output byte for '.'
//  out_valid   out  1     output handshake valid
//  out_ready   in   1     output handshake ready
//  in_data     in   8     input byte for ','
//  in_valid    in   1     input handshake valid
//  in_ready    out  1     input handshake ready
//  busy        out  1     1 in EXEC/SKIP_FWD/SKIP_BACK/WAIT_OUT/WAIT_IN
//  done        out  1     1 in HALT
//  error       out  1     1 in ERR
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, dp=0, depth=0; every output 0 the cycle after rst. rst wins over
//   all other inputs, incl. mid-skip or mid-handshake. Tape contents never cleared here.
//  States: IDLE, EXEC, SKIP_FWD, SKIP_BACK, WAIT_OUT, WAIT_IN, HALT, ERR.
//  IDLE/HALT/ERR + start=1 -> EXEC, pc=0, dp=0, depth=0. HALT/ERR hold until start or rst.
//  EXEC decodes prog_data, one instruction per cycle unless noted:
//   '+'0x2B/'-'0x2D: tape_we=1, tape_wdata=tape_rdata+/-1 mod 256; pc++.
//   '>'0x3E/'<'0x3C: dp+/-1 mod 2^DP_W (wraps both ways); pc++.
//   '.'0x2E: -> WAIT_OUT, out_data<=tape_rdata, out_valid=1 from next cycle.
//   ','0x2C: -> WAIT_IN, in_ready=1 from next cycle.
//   '['0x5B: cell==0 -> SKIP_FWD, depth=1, pc++; else pc++.
//   ']'0x5D: cell!=0 -> SKIP_BACK, depth=1, pc--; else pc++.
//   0x00: -> HALT. Any other byte: no-op, pc++.
//   pc++ from 2^PC_W-1 does not wrap: instruction completes, then -> HALT.
//  WAIT_OUT: out_valid, out_data stable until out_valid&out_ready; that cycle out_valid
//   drops next edge, pc++, -> EXEC. WAIT_IN: on in_valid&in_ready: tape_we=1,
//   tape_wdata=in_data, pc++, -> EXEC. Other signals ignored while waiting.
//  SKIP_FWD per cycle on prog_data: '[' depth++; ']' depth--; if depth hits 0 -> pc++,
//   EXEC; 0x00 or pc at 2^PC_W-1 without match -> ERR; else pc++.
//  SKIP_BACK per cycle: ']' depth++; '[' depth--; if depth hits 0 -> pc++ (one past
//   matching '['), EXEC; pc==0 without match -> ERR; else pc--.
//  depth increment beyond 2^DEPTH_W-1 -> ERR. No tape writes during SKIP_*.
// TESTING
//  1 prog "+++.",0x00, out_ready=1, start -> out_valid with out_data=0x03, then done=1.
//  2 "++[->+<]>." -> out_data=0x02; tape[0]=0x00, tape[1]=0x02; done=1, error=0.
//  3 "[+]." tape[0]=0 -> body skipped, tape_we never 1 in skip, out_data=0x00.
//  4 "," in_valid=0 for 5 cycles -> in_ready=1, pc frozen; in_valid=1,in_data=0x41 ->
//    tape[0]=0x41, next op fetched.
//  5 "<-." from dp=0 -> tape_addr=0xFF, cell 0x00->0xFF, out_data=0xFF (wrap).
//  6 "[[]" tape[0]=0 -> error=1; rst pulse during SKIP_FWD -> IDLE, all outputs 0.

Source files
------------

// File: rtl/bf_exec_sequencer.sv
// Fetch/decode/execute sequencer for the Brainf*ck core: walks program memory,
// drives the tape port, matches loop brackets and runs the byte I/O handshakes.
module bf_exec_sequencer #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned DP_W    = 8,
  parameter int unsigned DEPTH_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] prog_addr,
  input  logic [7:0]      prog_data,
  output logic [DP_W-1:0] tape_addr,
  input  logic [7:0]      tape_rdata,
  output logic [7:0]      tape_wdata,
  output logic            tape_we,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            busy,
  output logic            done,
  output logic            error
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_SKIP_FWD, S_SKIP_BACK, S_WAIT_OUT, S_WAIT_IN, S_HALT, S_ERR
  } state_t;

  localparam logic [7:0] OP_INC  = 8'h2B;
  localparam logic [7:0] OP_DEC  = 8'h2D;
  localparam logic [7:0] OP_RGT  = 8'h3E;
  localparam logic [7:0] OP_LFT  = 8'h3C;
  localparam logic [7:0] OP_OUT  = 8'h2E;
  localparam logic [7:0] OP_IN   = 8'h2C;
  localparam logic [7:0] OP_OPEN = 8'h5B;
  localparam logic [7:0] OP_CLS  = 8'h5D;
  localparam logic [7:0] OP_END  = 8'h00;

  state_t               state, state_nx;
  logic [PC_W-1:0]      pc, pc_nx;
  logic [DP_W-1:0]      dp, dp_nx;
  logic [DEPTH_W-1:0]   depth, depth_nx;
  logic [7:0]           out_q, out_nx;

  logic pc_last, pc_first, cell_zero, depth_max, depth_one;
  // adv: instruction finished, move on; step_fwd/step_back: keep scanning
  logic adv, step_fwd, step_back;

  assign pc_last   = (pc == '1);
  assign pc_first  = (pc == '0);
  assign cell_zero = (tape_rdata == 8'h00);
  assign depth_max = (depth == '1);
  assign depth_one = (depth == DEPTH_W'(1));

  assign prog_addr = pc;
  assign tape_addr = dp;
  assign out_data  = out_q;
  assign out_valid = (state == S_WAIT_OUT);
  assign in_ready  = (state == S_WAIT_IN);
  assign busy      = (state == S_EXEC) || (state == S_SKIP_FWD) || (state == S_SKIP_BACK) ||
                     (state == S_WAIT_OUT) || (state == S_WAIT_IN);
  assign done      = (state == S_HALT);
  assign error     = (state == S_ERR);

  // State and datapath registers; reset leaves tape contents alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      dp    <= '0;
      depth <= '0;
      out_q <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      dp    <= dp_nx;
      depth <= depth_nx;
      out_q <= out_nx;
    end
  end

  // Decode, bracket scanning and handshakes; pc never wraps past the last address.
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    dp_nx      = dp;
    depth_nx   = depth;
    out_nx     = out_q;
    tape_we    = 1'b0;
    tape_wdata = '0;
    adv        = 1'b0;
    step_fwd   = 1'b0;
    step_back  = 1'b0;

    case (state)
      S_IDLE, S_HALT, S_ERR: begin
        if (start) begin
          state_nx = S_EXEC;
          pc_nx    = '0;
          dp_nx    = '0;
          depth_nx = '0;
        end
      end
      S_EXEC: begin
        case (prog_data)
          OP_INC: begin
            tape_we    = 1'b1;
            tape_wdata = tape_rdata + 8'd1;
            adv        = 1'b1;
          end
          OP_DEC: begin
            tape_we    = 1'b1;
            tape_wdata = tape_rdata - 8'd1;
            adv        = 1'b1;
          end
          OP_RGT: begin
            dp_nx = dp + DP_W'(1);
            adv   = 1'b1;
          end
          OP_LFT: begin
            dp_nx = dp - DP_W'(1);
            adv   = 1'b1;
          end
          OP_OUT: begin
            out_nx   = tape_rdata;
            state_nx = S_WAIT_OUT;
          end
          OP_IN:  state_nx = S_WAIT_IN;
          OP_OPEN: begin
            if (cell_zero) begin
              depth_nx = DEPTH_W'(1);
              state_nx = S_SKIP_FWD;
              step_fwd = 1'b1;
            end else begin
              adv = 1'b1;
            end
          end
          OP_CLS: begin
            if (!cell_zero) begin
              depth_nx  = DEPTH_W'(1);
              state_nx  = S_SKIP_BACK;
              step_back = 1'b1;
            end else begin
              adv = 1'b1;
            end
          end
          OP_END:  state_nx = S_HALT;
          default: adv = 1'b1;
        endcase
      end
      S_SKIP_FWD: begin
        case (prog_data)
          OP_OPEN: begin
            if (depth_max) begin
              state_nx = S_ERR;
            end else begin
              depth_nx = depth + DEPTH_W'(1);
              step_fwd = 1'b1;
            end
          end
          OP_CLS: begin
            depth_nx = depth - DEPTH_W'(1);
            if (depth_one) adv = 1'b1;
            else step_fwd = 1'b1;
          end
          OP_END:  state_nx = S_ERR;
          default: step_fwd = 1'b1;
        endcase
      end
      S_SKIP_BACK: begin
        case (prog_data)
          OP_CLS: begin
            if (depth_max) begin
              state_nx = S_ERR;
            end else begin
              depth_nx  = depth + DEPTH_W'(1);
              step_back = 1'b1;
            end
          end
          OP_OPEN: begin
            depth_nx = depth - DEPTH_W'(1);
            if (depth_one) adv = 1'b1;
            else step_back = 1'b1;
          end
          default: step_back = 1'b1;
        endcase
      end
      S_WAIT_OUT: begin
        if (out_ready) adv = 1'b1;
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          tape_we    = 1'b1;
          tape_wdata = in_data;
          adv        = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // Shared pc-step tails; running off either end of program memory is terminal.
    if (adv) begin
      if (pc_last) begin
        state_nx = S_HALT;
      end else begin
        pc_nx    = pc + PC_W'(1);
        state_nx = S_EXEC;
      end
    end
    if (step_fwd) begin
      if (pc_last) state_nx = S_ERR;
      else pc_nx = pc + PC_W'(1);
    end
    if (step_back) begin
      if (pc_first) state_nx = S_ERR;
      else pc_nx = pc - PC_W'(1);
    end
  end

endmodule

// File: tb/tb_bf_exec_sequencer.sv
// Bench for bf_exec_sequencer: program-level interpreter model plus directed cases.
module tb_bf_exec_sequencer;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] prog_addr, prog_data, tape_addr, tape_rdata, tape_wdata;
  logic       tape_we;
  logic [7:0] out_data, in_data;
  logic       out_valid, out_ready, in_valid, in_ready, busy, done, error;

  int checks = 0;
  int failures = 0;

  logic [7:0] rom  [256];
  logic [7:0] tape [256];
  logic [7:0] mt   [256];
  logic [7:0] inq  [64];
  logic       tape_clr = 1'b0;
  logic       mon_en = 1'b0;

  logic [7:0]  m_out[$];
  logic [7:0]  exp_out[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  got_out[$];

  localparam int BUDGET = 6000;

  bf_exec_sequencer #(.PC_W(8), .DP_W(8), .DEPTH_W(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .tape_addr(tape_addr), .tape_rdata(tape_rdata), .tape_wdata(tape_wdata), .tape_we(tape_we),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  assign prog_data  = rom[prog_addr];
  assign tape_rdata = tape[tape_addr];

  // tape RAM: writes on the edge where tape_we is high; bench may wipe it between runs
  always @(posedge clk) begin
    if (tape_clr) begin
      for (int i = 0; i < 256; i++) tape[i] <= 8'h00;
    end else if (tape_we) begin
      tape[tape_addr] <= tape_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // compare process: every tape write and every output handshake against the model
  always @(negedge clk) begin
    if (mon_en) begin
      if (tape_we) begin
        check("write_while_busy", {31'd0, busy}, 32'd1);
        if (exp_wr.size() == 0) check("unexpected_write", {16'd0, tape_addr, tape_wdata}, 32'hFFFF_FFFF);
        else check("tape_write", {16'd0, tape_addr, tape_wdata}, {16'd0, exp_wr.pop_front()});
      end
      if (out_valid && out_ready) begin
        got_out.push_back(out_data);
        if (exp_out.size() == 0) check("unexpected_out", {24'd0, out_data}, 32'hFFFF_FFFF);
        else check("out_byte", {24'd0, out_data}, {24'd0, exp_out.pop_front()});
      end
    end
  end

  // Program-level interpreter: status 1=halt, 2=error, 0=too long, 3=ran out of input.
  task automatic model_run(output int status);
    int pc, dp, d, p, steps, ii;
    logic [7:0] op;
    mt = tape;
    m_out.delete(); exp_wr.delete();
    pc = 0; dp = 0; ii = 0; steps = 0; status = 0;
    while (status == 0 && steps < 1500) begin
      steps++;
      if (pc > 255) begin
        status = 1;
      end else begin
        op = rom[pc];
        case (op)
          8'h00: status = 1;
          8'h2B, 8'h2D: begin
            mt[dp] = (op == 8'h2B) ? 8'(mt[dp] + 8'd1) : 8'(mt[dp] - 8'd1);
            exp_wr.push_back({dp[7:0], mt[dp]});
            pc++;
          end
          8'h3E: begin dp = (dp + 1) % 256; pc++; end
          8'h3C: begin dp = (dp + 255) % 256; pc++; end
          8'h2E: begin m_out.push_back(mt[dp]); pc++; end
          8'h2C: begin
            if (ii >= 64) status = 3;
            else begin
              mt[dp] = inq[ii]; ii++;
              exp_wr.push_back({dp[7:0], mt[dp]});
              pc++;
            end
          end
          8'h5B: begin
            if (mt[dp] == 8'h00) begin
              d = 1; p = pc + 1; pc = -1;
              while (p < 256) begin
                steps++;
                if (rom[p] == 8'h5B) begin
                  if (d == 15) break;
                  d++;
                end else if (rom[p] == 8'h5D) begin
                  d--;
                  if (d == 0) begin pc = p + 1; break; end
                end else if (rom[p] == 8'h00) begin
                  break;
                end
                p++;
              end
              if (pc == -1) status = 2;
            end else pc++;
          end
          8'h5D: begin
            if (mt[dp] != 8'h00) begin
              d = 1; p = pc - 1; pc = -1;
              while (p >= 0) begin
                steps++;
                if (rom[p] == 8'h5D) begin
                  if (d == 15) break;
                  d++;
                end else if (rom[p] == 8'h5B) begin
                  d--;
                  if (d == 0) begin pc = p + 1; break; end
                end
                p--;
              end
              if (pc == -1) status = 2;
            end else pc++;
          end
          default: pc++;
        endcase
      end
    end
    exp_out = m_out;
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) rom[i] = s[i];
  endtask

  task automatic clear_tape();
    @(posedge clk); #1 tape_clr = 1'b1;
    @(posedge clk); #1 tape_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Runs the loaded program on model and DUT with random handshake timing.
  task automatic run_prog(input string name, input bit ready_always, output int mst);
    int cyc, idx, bad;
    bit hs;
    model_run(mst);
    got_out.delete();
    mon_en = 1'b1;
    pulse_start();
    cyc = 0; idx = 0;
    while (!(done || error) && cyc < BUDGET) begin
      out_ready = ready_always ? 1'b1 : 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = (idx < 64) ? inq[idx] : 8'h00;
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check({name, "_timeout"}, (cyc < BUDGET) ? 32'd1 : 32'd0, 32'd1);
    check({name, "_status"}, {29'd0, busy, done, error},
          {29'd0, 1'b0, (mst == 1) ? 1'b1 : 1'b0, (mst == 2) ? 1'b1 : 1'b0});
    check({name, "_left"}, exp_wr.size() + exp_out.size(), 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (tape[i] !== mt[i]) bad++;
    check({name, "_tape"}, bad, 32'd0);
    mon_en = 1'b0;
  endtask

  task automatic gen_random();
    string tbl;
    int len;
    tbl = "++--><<>..,[]]A";
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    len = $urandom_range(6, 40);
    for (int i = 0; i < len; i++) rom[i] = tbl[$urandom_range(0, tbl.len() - 1)];
    for (int i = 0; i < 64; i++) inq[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int st, n;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    for (int i = 0; i < 64; i++) inq[i] = 8'h00;
    clear_tape();
    @(posedge clk); #1 rst = 1'b0;
    check("reset_outputs", {prog_addr, tape_addr, tape_wdata, out_data}, 32'd0);
    check("reset_flags", {26'd0, tape_we, out_valid, in_ready, busy, done, error}, 32'd0);

    // 1: "+++." with out_ready held high
    load_str("+++.");
    run_prog("t1", 1'b1, st);
    check("t1_model_out", {24'd0, m_out[0]}, 32'h03);
    check("t1_nout", got_out.size(), 32'd1);
    check("t1_out", {24'd0, got_out[0]}, 32'h03);
    check("t1_done", {31'd0, done}, 32'd1);

    // 2: move loop
    clear_tape();
    load_str("++[->+<]>.");
    run_prog("t2", 1'b0, st);
    check("t2_model_out", {24'd0, m_out[0]}, 32'h02);
    check("t2_out", {24'd0, got_out[0]}, 32'h02);
    check("t2_tape", {16'd0, tape[0], tape[1]}, 32'h0002);
    check("t2_flags", {30'd0, done, error}, 32'd2);

    // 3: skipped loop body never writes
    clear_tape();
    load_str("[+].");
    run_prog("t3", 1'b0, st);
    check("t3_out", {24'd0, got_out[0]}, 32'h00);
    check("t3_nout", got_out.size(), 32'd1);

    // 4: input stall then byte 0x41
    clear_tape();
    load_str(",");
    pulse_start();
    n = 0;
    while (!in_ready && n < 10) begin @(posedge clk); #1; n++; end
    check("t4_reach_wait", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_stall", {22'd0, in_ready, tape_we, prog_addr}, {22'd0, 1'b1, 1'b0, 8'h00});
    end
    @(posedge clk); #1 in_data = 8'h41; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    check("t4_tape0", {24'd0, tape[0]}, 32'h41);
    check("t4_next_pc", {23'd0, in_ready, prog_addr}, {23'd0, 1'b0, 8'h01});
    @(posedge clk); #1;
    check("t4_done", {31'd0, done}, 32'd1);

    // 5: pointer wraps below zero
    clear_tape();
    load_str("<-.");
    run_prog("t5", 1'b0, st);
    check("t5_out", {24'd0, got_out[0]}, 32'hFF);
    check("t5_cell", {16'd0, tape_addr, tape[255]}, 32'hFFFF);

    // 6a: unmatched bracket
    clear_tape();
    load_str("[[]");
    run_prog("t6", 1'b0, st);
    check("t6_error", {30'd0, done, error}, 32'd1);

    // 6b: reset in the middle of a forward skip
    for (int i = 0; i < 256; i++) rom[i] = 8'h01;
    rom[0] = 8'h5B; rom[61] = 8'h5D; rom[62] = 8'h00;
    pulse_start();
    repeat (5) @(posedge clk);
    #1 check("t6_skipping", {30'd0, busy, tape_we}, 32'd2);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("t6_rst_outputs", {prog_addr, tape_addr, tape_wdata, out_data}, 32'd0);
    check("t6_rst_flags", {26'd0, tape_we, out_valid, in_ready, busy, done, error}, 32'd0);

    // boundaries: nesting depth limit and running off the end of program memory
    clear_tape();
    load_str("[[[[[[[[[[[[[[[]]]]]]]]]]]]]]].");
    run_prog("depth15", 1'b0, st);
    check("depth15_out", got_out.size(), 32'd1);
    load_str("[[[[[[[[[[[[[[[[]]]]]]]]]]]]]]]].");
    run_prog("depth16", 1'b0, st);
    check("depth16_error", {31'd0, error}, 32'd1);
    clear_tape();
    for (int i = 0; i < 256; i++) rom[i] = 8'h2B;
    rom[255] = 8'h3E;
    run_prog("pc_end", 1'b0, st);
    check("pc_end_state", {23'd0, done, tape_addr}, {23'd0, 1'b1, 8'h01});
    check("pc_end_cell", {24'd0, tape[0]}, 32'hFF);

    // random programs; tape carries over between runs
    for (int t = 0; t < 14; t++) begin
      st = 0;
      for (int a = 0; a < 50 && !(st == 1 || st == 2); a++) begin
        gen_random();
        model_run(st);
      end
      if (st == 1 || st == 2) run_prog("rand", 1'b0, st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
